or8_result_checker: RTL and testbench
=====================================

OR8_RESULT_CHECKER -- requirements
Module: or8_result_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 16, number of samples per run (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the idle-cycle limit in RUN (legal range 1..65535; used only with OR8_CHK_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-006 The block SHALL have port in_valid  in  1  sample (a, b, y) presented.
REQ-007 The block SHALL have port in_ready  out  1  checker accepts a sample this cycle.
REQ-008 The block SHALL have ports a, b, y  in  8 each  operands and DUT result under check.
REQ-009 The block SHALL have ports pass_cnt, fail_cnt  out  8 each  matching and mismatching sample counts.
REQ-010 The block SHALL have ports err_valid  out  1, and err_a, err_b, err_y  out  8 each  first-mismatch capture.
REQ-011 The block SHALL have ports done  out  1, all_pass  out  1, timeout  out  1  run status.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 IDLE->RUN on start; that edge clears pass_cnt, fail_cnt, err_*, the sample counter, done and timeout.
REQ-014 in_ready SHALL be 1 only in RUN; a sample is accepted on an edge where in_valid && in_ready.
REQ-015 The expected result SHALL be a | b, computed combinationally; match means y == (a | b) in all 8 bits.
REQ-016 On acceptance, pass_cnt or fail_cnt SHALL increment on the same edge, so the new value is visible the next cycle; both counters saturate at 255.
REQ-017 On the first mismatch of a run, err_a/err_b/err_y SHALL capture the sample and err_valid SHALL set; later mismatches do not overwrite the capture.
REQ-018 RUN->DONE on the edge accepting sample number NUM_VECTORS; done SHALL be 1 in DONE only.
REQ-019 all_pass SHALL equal done && fail_cnt==0 && !timeout.
REQ-020 start SHALL be ignored in RUN; start in DONE SHALL behave as in IDLE (clear and enter RUN).
REQ-021 in_valid SHALL be ignored outside RUN; no counter changes.

Reset
REQ-022 rst SHALL force state IDLE and all outputs to 0 (pass_cnt, fail_cnt, err_* = 8'h00), overriding start and in_valid on the same edge.
REQ-023 rst asserted mid-run SHALL abandon the run; the next run requires a fresh start.

Configuration
REQ-024 Macro OR8_CHK_TIMEOUT_EN SHALL, when defined, add a 16-bit idle counter that is cleared on entering RUN and on every acceptance and increments each RUN cycle with no acceptance; on reaching TIMEOUT, the FSM goes to DONE and timeout is set.
REQ-025 When OR8_CHK_TIMEOUT_EN is undefined, the idle counter SHALL not exist, timeout SHALL be constant 0, and RUN waits indefinitely.
REQ-026 If the idle counter reaches TIMEOUT on the same edge as the final acceptance, the acceptance SHALL win: DONE is entered with timeout=0.

Structure
REQ-027 Package or8_chk_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant CNT_MAX=8'hFF.
REQ-028 One sub-module, or8_sat_counter (8-bit saturating increment with clear), SHALL be instantiated twice, for pass_cnt and fail_cnt; the remaining logic is flat.

Verification
REQ-029 NUM_VECTORS=2; start; samples (1C,11,1D), (B2,F4,F6) -> pass_cnt=2, fail_cnt=0, done=1, all_pass=1.
REQ-030 Samples (1C,11,1C), (B2,F4,00) -> fail_cnt=2, err_valid=1, err_a=1C, err_b=11, err_y=1C (first mismatch held).
REQ-031 NUM_VECTORS=255; 255 mismatching samples plus one extra in_valid in DONE -> fail_cnt=255, done=1, extra sample not counted.
REQ-032 rst after 1 accepted sample, then start; 2 passing samples -> pass_cnt=2, fail_cnt=0.
REQ-033 With OR8_CHK_TIMEOUT_EN and TIMEOUT=4: start, no in_valid -> DONE with timeout=1 after 4 RUN cycles; all_pass=0.
REQ-034 start pulsed during RUN -> ignored, counters keep accumulating; start in DONE -> counters cleared, RUN re-entered.

Source files
------------

// File: rtl/or8_chk_pkg.sv
// Shared FSM state encoding and counter ceiling for the OR8 result checker.
package or8_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/or8_sat_counter.sv
// 8-bit counter that increments up to CNT_MAX and holds there; clr wins over inc.
// Latency: the incremented value appears the cycle after inc. No backpressure.
module or8_sat_counter
  import or8_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (clr) begin
      q <= 8'h00;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + 8'd1;
    end
  end

endmodule

// File: rtl/or8_result_checker.sv
// Checks y == a | b over a run of NUM_VECTORS samples; counts passes/fails, holds the first mismatch.
// Latency: counts are visible the cycle after acceptance. in_ready is high only in RUN.
// Optional OR8_CHK_TIMEOUT_EN: ends a run after TIMEOUT consecutive RUN cycles without a sample.
module or8_result_checker
  import or8_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] y,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic       err_valid,
  output logic [7:0] err_a,
  output logic [7:0] err_b,
  output logic [7:0] err_y,
  output logic       done,
  output logic       all_pass,
  output logic       timeout
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 255) begin : g_bad_num_vectors
    $error("or8_result_checker: NUM_VECTORS out of range 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("or8_result_checker: TIMEOUT out of range 1..65535");
  end

  state_t     state, state_nxt;
  logic       start_run;
  logic       accept;
  logic       match;
  logic       last;
  logic       to_hit;
  logic [7:0] smp_cnt;

  assign start_run = start && (state != RUN);
  assign accept    = (state == RUN) && in_valid;
  assign match     = (y == (a | b));
  assign last      = accept && (smp_cnt == 8'(NUM_VECTORS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A final acceptance takes priority over an idle timeout on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last || to_hit) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt <= 8'h00;
    end else if (start_run) begin
      smp_cnt <= 8'h00;
    end else if (accept) begin
      smp_cnt <= smp_cnt + 8'd1;
    end
  end

`ifdef OR8_CHK_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout_q;

  assign to_hit  = (state == RUN) && !accept && (idle_cnt == 16'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= 16'h0000;
      timeout_q <= 1'b0;
    end else if (start_run) begin
      idle_cnt  <= 16'h0000;
      timeout_q <= 1'b0;
    end else if (state == RUN) begin
      if (accept) begin
        idle_cnt <= 16'h0000;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (to_hit && !last) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Only the first mismatch of a run is captured; err_valid locks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_a     <= 8'h00;
      err_b     <= 8'h00;
      err_y     <= 8'h00;
    end else if (start_run) begin
      err_valid <= 1'b0;
      err_a     <= 8'h00;
      err_b     <= 8'h00;
      err_y     <= 8'h00;
    end else if (accept && !match && !err_valid) begin
      err_valid <= 1'b1;
      err_a     <= a;
      err_b     <= b;
      err_y     <= y;
    end
  end

  or8_sat_counter u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_run),
    .inc (accept && match),
    .q   (pass_cnt)
  );

  or8_sat_counter u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_run),
    .inc (accept && !match),
    .q   (fail_cnt)
  );

  assign in_ready = (state == RUN);
  assign done     = (state == DONE);
  assign all_pass = done && (fail_cnt == 8'h00) && !timeout;

endmodule

// File: tb/tb_or8_result_checker.sv
// Directed bench for or8_result_checker: a 2-vector instance and a 255-vector instance.
module tb_or8_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic       in_valid = 1'b0, in_valid2 = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00, y = 8'h00;

  logic       in_ready, err_valid, done, all_pass, timeout;
  logic [7:0] pass_cnt, fail_cnt, err_a, err_b, err_y;
  logic       in_ready2, err_valid2, done2, all_pass2, timeout2;
  logic [7:0] pass_cnt2, fail_cnt2, err_a2, err_b2, err_y2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  or8_result_checker #(.NUM_VECTORS(2), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .y(y), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_y(err_y),
    .done(done), .all_pass(all_pass), .timeout(timeout)
  );

  or8_result_checker #(.NUM_VECTORS(255), .TIMEOUT(255)) u_big (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .y(y), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
    .err_valid(err_valid2), .err_a(err_a2), .err_b(err_b2), .err_y(err_y2),
    .done(done2), .all_pass(all_pass2), .timeout(timeout2)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sy);
    a = sa; b = sb; y = sy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // reset overrides start and in_valid on the same edges
    start = 1'b1; in_valid = 1'b1; start2 = 1'b1; in_valid2 = 1'b1;
    tick(); tick();
    check("rst_pass",     16'(pass_cnt),  16'h00);
    check("rst_fail",     16'(fail_cnt),  16'h00);
    check("rst_err_vld",  16'(err_valid), 16'h0);
    check("rst_err_a",    16'(err_a),     16'h00);
    check("rst_done",     16'(done),      16'h0);
    check("rst_all_pass", 16'(all_pass),  16'h0);
    check("rst_timeout",  16'(timeout),   16'h0);
    check("rst_ready",    16'(in_ready),  16'h0);
    check("rst_ready2",   16'(in_ready2), 16'h0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    tick();

    // samples in IDLE are ignored
    send(8'h1C, 8'h11, 8'h1D);
    check("idle_ignore_pass", 16'(pass_cnt), 16'h00);
    check("idle_ready",       16'(in_ready), 16'h0);

    // two passing samples
    pulse_start();
    check("run_ready", 16'(in_ready), 16'h1);
    send(8'h1C, 8'h11, 8'h1D);
    check("p1_pass", 16'(pass_cnt), 16'h01);
    check("p1_done", 16'(done),     16'h0);
    send(8'hB2, 8'hF4, 8'hF6);
    check("p2_pass",     16'(pass_cnt), 16'h02);
    check("p2_fail",     16'(fail_cnt), 16'h00);
    check("p2_done",     16'(done),     16'h1);
    check("p2_all_pass", 16'(all_pass), 16'h1);
    check("p2_ready",    16'(in_ready), 16'h0);
    send(8'h00, 8'h00, 8'h00);
    check("done_ignore_pass", 16'(pass_cnt), 16'h02);

    // restart from DONE, two mismatches, first one held
    pulse_start();
    check("restart_pass", 16'(pass_cnt), 16'h00);
    check("restart_done", 16'(done),     16'h0);
    send(8'h1C, 8'h11, 8'h1C);
    check("m1_err_vld", 16'(err_valid), 16'h1);
    check("m1_err_y",   16'(err_y),     16'h1C);
    send(8'hB2, 8'hF4, 8'h00);
    check("m2_fail",     16'(fail_cnt), 16'h02);
    check("m2_err_a",    16'(err_a),    16'h1C);
    check("m2_err_b",    16'(err_b),    16'h11);
    check("m2_err_y",    16'(err_y),    16'h1C);
    check("m2_done",     16'(done),     16'h1);
    check("m2_all_pass", 16'(all_pass), 16'h0);

    // start during RUN is ignored
    pulse_start();
    check("clr_err_vld", 16'(err_valid), 16'h0);
    send(8'h0F, 8'hF0, 8'hFF);
    pulse_start();
    check("mid_start_pass",  16'(pass_cnt), 16'h01);
    check("mid_start_ready", 16'(in_ready), 16'h1);
    send(8'h00, 8'h00, 8'h00);
    check("mid_start_pass2", 16'(pass_cnt), 16'h02);
    check("mid_start_done",  16'(done),     16'h1);

    // reset mid-run abandons the run
    pulse_start();
    send(8'h01, 8'h02, 8'h03);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_pass",  16'(pass_cnt), 16'h00);
    check("midrst_ready", 16'(in_ready), 16'h0);
    send(8'h01, 8'h02, 8'h03);
    check("midrst_ignore", 16'(pass_cnt), 16'h00);
    pulse_start();
    send(8'h55, 8'hAA, 8'hFF);
    send(8'h80, 8'h01, 8'h81);
    check("rerun_pass", 16'(pass_cnt), 16'h02);
    check("rerun_fail", 16'(fail_cnt), 16'h00);
    check("rerun_done", 16'(done),     16'h1);

    // idle behaviour in RUN
    pulse_start();
`ifdef OR8_CHK_TIMEOUT_EN
    tick(); tick(); tick();
    check("to_early_done", 16'(done), 16'h0);
    tick();
    check("to_done",     16'(done),     16'h1);
    check("to_timeout",  16'(timeout),  16'h1);
    check("to_all_pass", 16'(all_pass), 16'h0);
`else
    for (int i = 0; i < 10; i++) tick();
    check("noto_done",    16'(done),     16'h0);
    check("noto_timeout", 16'(timeout),  16'h0);
    check("noto_ready",   16'(in_ready), 16'h1);
    send(8'h01, 8'h01, 8'h01);
    send(8'h02, 8'h02, 8'h02);
    check("noto_all_pass", 16'(all_pass), 16'h1);
`endif

    // 255-vector run, all mismatching (y = (a|b) ^ 1)
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 255; i++) begin
      a = 8'(i); b = 8'h00; y = 8'(i) ^ 8'h01;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      if (i == 253) check("big_254_done", 16'(done2), 16'h0);
    end
    check("big_fail",    16'(fail_cnt2),  16'hFF);
    check("big_pass",    16'(pass_cnt2),  16'h00);
    check("big_done",    16'(done2),      16'h1);
    check("big_err_a",   16'(err_a2),     16'h00);
    check("big_err_y",   16'(err_y2),     16'h01);
    a = 8'h10; b = 8'h01; y = 8'h00;
    in_valid2 = 1'b1; tick(); in_valid2 = 1'b0;
    check("big_extra_fail", 16'(fail_cnt2), 16'hFF);
    check("big_extra_done", 16'(done2),     16'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
